// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the parametrised UART receive controller.
// Optional majority-vote sampling is enabled by defining UART_RX_MAJ3_EN.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP_A = 3'd4,
        STOP_B = 3'd5
    } rx_state_e;

    localparam int PRESC_MIN = 4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// RX synchroniser, per-bit edge counter and bit-value decision for uart_rx_ctrl_p.
// With UART_RX_MAJ3_EN defined the bit value is a 2-of-3 vote around mid-bit.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               rx_in,
    input  logic               start,
    input  logic               run,
    input  logic [PRESC_W-1:0] prescale,
    output logic               rx_s,
    output logic               samp_valid,
    output logic               samp_bit,
    output logic               bit_end
);

    logic               rx_meta;
    logic [PRESC_W-1:0] p_q;
    logic [PRESC_W-1:0] edge_cnt;
    logic [PRESC_W-1:0] half;
    logic [PRESC_W-1:0] p_eff;

    assign p_eff   = (prescale < PRESC_W'(PRESC_MIN)) ? PRESC_W'(PRESC_MIN) : prescale;
    assign half    = p_q >> 1;
    assign bit_end = run && (edge_cnt == (p_q - PRESC_W'(1)));

    // Idle-high line: both synchroniser flops come out of reset at 1.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            p_q      <= PRESC_W'(PRESC_MIN);
            edge_cnt <= '0;
        end else if (start) begin
            p_q      <= p_eff;
            edge_cnt <= '0;
        end else if (run) begin
            edge_cnt <= bit_end ? '0 : edge_cnt + PRESC_W'(1);
        end
    end

`ifdef UART_RX_MAJ3_EN
    logic s0;
    logic s1;

    // Collect the two samples ahead of the decision; the third is the live rx_s.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else if (run) begin
            if (edge_cnt == (half - PRESC_W'(1))) s0 <= rx_s;
            if (edge_cnt == half)                 s1 <= rx_s;
        end
    end

    assign samp_valid = run && (edge_cnt == (half + PRESC_W'(1)));
    assign samp_bit   = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
`else
    assign samp_valid = run && (edge_cnt == half);
    assign samp_bit   = rx_s;
`endif

endmodule

// File: rtl/uart_rx_ctrl_p.sv
// UART receive controller: frame FSM, bit counter, deserialiser, parity and stop checks.
// Define UART_RX_MAJ3_EN to switch the sampler to 2-of-3 majority decisions.
module uart_rx_ctrl_p
    import uart_rx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6,
    parameter int CNT_W   = 4
) (
    input  logic               CLK,
    input  logic               rst_n,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic               PAR_TYP,
    input  logic               STOP2,
    input  logic [PRESC_W-1:0] Prescale,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err,
    output logic               strt_glitch,
    output logic               busy
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
    localparam logic [2:0] S_PARITY = PARITY;
    localparam logic [2:0] S_STOP_A = STOP_A;
    localparam logic [2:0] S_STOP_B = STOP_B;

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_q;
    logic              par_en_q;
    logic              par_typ_q;
    logic              stop2_q;

    logic rx_s;
    logic samp_valid;
    logic samp_bit;
    logic bit_end;
    logic start_det;
    logic run;
    logic glitch;
    logic par_bad;
    logic stop_bad;
    logic frame_end;
    logic frame_good;
    logic exp_par;

    uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .rx_in      (RX_IN),
        .start      (start_det),
        .run        (run),
        .prescale   (Prescale),
        .rx_s       (rx_s),
        .samp_valid (samp_valid),
        .samp_bit   (samp_bit),
        .bit_end    (bit_end)
    );

    assign start_det = (state_q == S_IDLE) && !rx_s;
    assign run       = (state_q != S_IDLE);
    assign exp_par   = (^shift_q) ^ (par_typ_q != PAR_EVEN);

    always_comb begin
        state_d   = state_q;
        glitch    = 1'b0;
        par_bad   = 1'b0;
        stop_bad  = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) state_d = S_START;
            end
            S_START: begin
                if (samp_valid && samp_bit) begin
                    glitch  = 1'b1;
                    state_d = S_IDLE;
                end else if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // bit_cnt already counts the start bit, so DATA_W here is the last data bit.
                if (bit_end && (bit_cnt == CNT_W'(DATA_W)))
                    state_d = par_en_q ? S_PARITY : S_STOP_A;
            end
            S_PARITY: begin
                if (samp_valid && (samp_bit != exp_par)) par_bad = 1'b1;
                if (bit_end) state_d = S_STOP_A;
            end
            S_STOP_A: begin
                if (samp_valid) begin
                    stop_bad = !samp_bit;
                    if (!stop2_q) begin
                        frame_end = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                if (stop2_q && bit_end) state_d = S_STOP_B;
            end
            S_STOP_B: begin
                if (samp_valid) begin
                    stop_bad  = !samp_bit;
                    frame_end = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign frame_good = !(par_err || par_bad || stp_err || stop_bad);

    // data_valid is a one-cycle strobe with no ready/backpressure: the consumer
    // must take data_out on the cycle data_valid is high; data_out then holds.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy        <= 1'b0;
            strt_glitch <= 1'b0;
            data_valid  <= 1'b0;
            data_out    <= '0;
        end else begin
            state_q     <= state_d;
            busy        <= (state_d != S_IDLE);
            strt_glitch <= glitch;
            data_valid  <= frame_end && frame_good;
            if (frame_end && frame_good) data_out <= shift_q;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            stop2_q   <= 1'b0;
            par_err   <= 1'b0;
            stp_err   <= 1'b0;
        end else if (start_det) begin
            bit_cnt   <= '0;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP ? PAR_ODD : PAR_EVEN;
            stop2_q   <= STOP2;
            par_err   <= 1'b0;
            stp_err   <= 1'b0;
        end else begin
            if (bit_end)  bit_cnt <= bit_cnt + CNT_W'(1);
            if (par_bad)  par_err <= 1'b1;
            if (stop_bad) stp_err <= 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
        end else if (samp_valid && (state_q == S_DATA)) begin
            shift_q <= {samp_bit, shift_q[DATA_W-1:1]};
        end
    end

endmodule
